// File: rtl/crc16_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : crc16_frame_checker
// Description : Receive-side CRC-16 checker (x^16+x^12+x^5+1). Accepts a byte
//               stream (payload, then CRC high byte, then CRC low byte) over a
//               valid/ready handshake, divides it bit-serially MSB first and
//               reports at end of frame whether the remainder is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module crc16_frame_checker #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        len_err,
    output logic [15:0] residue,
    output logic [15:0] frame_len
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    logic [7:0]  r_sreg;
    logic        r_last;
    logic [2:0]  r_bit_cnt;
    logic [15:0] r_crc;
    logic [15:0] r_byte_cnt;
    logic        r_in_ready;
    logic        r_frame_done;
    logic        r_crc_ok;
    logic        r_len_err;
    logic [15:0] r_residue;
    logic [15:0] r_frame_len;

    logic        w_fb;
    logic [15:0] w_crc_next;
    logic        w_xfer;
    logic        w_len_err;

    // One polynomial-division step on the current MSB of the shift register.
    // The final step's result feeds the frame result directly so the outputs
    // are valid in the same cycle frame_done rises.
    assign w_fb       = r_crc[15] ^ r_sreg[7];
    assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);
    assign w_xfer     = in_valid && r_in_ready;
    assign w_len_err  = (r_byte_cnt < 16'd2);

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sreg       <= 8'h00;
            r_last       <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_crc        <= INIT;
            r_byte_cnt   <= 16'h0000;
            r_in_ready   <= 1'b1;
            r_frame_done <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_len_err    <= 1'b0;
            r_residue    <= 16'h0000;
            r_frame_len  <= 16'h0000;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_sreg     <= in_data;
                        r_last     <= in_last;
                        r_bit_cnt  <= 3'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                        if (r_byte_cnt != C_CNT_MAX) begin
                            r_byte_cnt <= r_byte_cnt + 16'd1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_crc     <= w_crc_next;
                    r_sreg    <= {r_sreg[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (r_last) begin
                            // Byte count already includes this last byte.
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                            r_residue    <= w_crc_next;
                            r_len_err    <= w_len_err;
                            r_crc_ok     <= (w_crc_next == 16'h0000) && !w_len_err;
                            r_frame_len  <= r_byte_cnt;
                        end else begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_crc      <= INIT;
                    r_byte_cnt <= 16'h0000;
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign frame_done = r_frame_done;
    assign crc_ok     = r_crc_ok;
    assign len_err    = r_len_err;
    assign residue    = r_residue;
    assign frame_len  = r_frame_len;

endmodule
`default_nettype wire

// File: tb/tb_crc16_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc16_frame_checker
// Description : Self-checking bench for crc16_frame_checker. Frame vectors with
//               expected results are kept in a table; expectations go to a
//               scoreboard queue when a frame is driven and are popped on each
//               frame_done. Held outputs, pulse timing and in_ready are watched
//               every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc16_frame_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        frame_done;
    logic        crc_ok;
    logic        len_err;
    logic [15:0] residue;
    logic [15:0] frame_len;

    crc16_frame_checker #(
        .POLY (16'h1021),
        .INIT (16'h0000)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .len_err    (len_err),
        .residue    (residue),
        .frame_len  (frame_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data [16];
        int          len;
        logic        ok;
        logic        le;
        logic [15:0] res;
        logic [15:0] flen;
    } vec_t;

    typedef struct {
        logic        ok;
        logic        le;
        logic [15:0] res;
        logic [15:0] flen;
    } exp_t;

    localparam int C_NVEC = 8;

    vec_t vecs [C_NVEC];
    exp_t sb_q [$];

    int compared = 0;
    int mismatched = 0;

    // Monitor state
    int          cyc = 0;
    int          xfer_n = 0;
    int          busy_until = 0;
    int          done_at = -1;
    logic        m_ok = 1'b0;
    logic        m_le = 1'b0;
    logic [15:0] m_res = 16'h0000;
    logic [15:0] m_len = 16'h0000;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_vec(input int idx, input logic [7:0] b [16], input int n,
                           input logic ok, input logic le, input logic [15:0] res);
        vecs[idx].data = b;
        vecs[idx].len  = n;
        vecs[idx].ok   = ok;
        vecs[idx].le   = le;
        vecs[idx].res  = res;
        vecs[idx].flen = 16'(n);
    endtask

    // Drive one byte and return on the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        int budget;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
            $fatal(1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int idx, input bit gaps);
        exp_t e;
        e.ok   = vecs[idx].ok;
        e.le   = vecs[idx].le;
        e.res  = vecs[idx].res;
        e.flen = vecs[idx].flen;
        sb_q.push_back(e);
        for (int i = 0; i < vecs[idx].len; i++) begin
            send_byte(vecs[idx].data[i], (i == vecs[idx].len - 1),
                      gaps ? int'($urandom_range(0, 12)) : 0);
        end
    endtask

    // Per-cycle monitor, sampled just after the falling edge.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            busy_until = 0;
            done_at    = -1;
            m_ok = 1'b0; m_le = 1'b0; m_res = 16'h0000; m_len = 16'h0000;
            check("rst_in_ready", {15'd0, in_ready}, 16'd1);
            check("rst_frame_done", {15'd0, frame_done}, 16'd0);
            check("rst_crc_ok", {15'd0, crc_ok}, 16'd0);
            check("rst_len_err", {15'd0, len_err}, 16'd0);
            check("rst_residue", residue, 16'h0000);
            check("rst_frame_len", frame_len, 16'h0000);
        end else begin
            if (cyc > xfer_n && cyc <= busy_until) begin
                check("ready_while_busy", {15'd0, in_ready}, 16'd0);
            end
            if (frame_done) begin
                check("done_timing", 16'(cyc - done_at), 16'd0);
                done_at = -1;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 16'd1, 16'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("crc_ok", {15'd0, crc_ok}, {15'd0, e.ok});
                    check("len_err", {15'd0, len_err}, {15'd0, e.le});
                    check("residue", residue, e.res);
                    check("frame_len", frame_len, e.flen);
                    m_ok = e.ok; m_le = e.le; m_res = e.res; m_len = e.flen;
                end
            end else begin
                if (cyc == done_at) begin
                    check("missing_done", {15'd0, frame_done}, 16'd1);
                    done_at = -1;
                end
                check("held_crc_ok", {15'd0, crc_ok}, {15'd0, m_ok});
                check("held_len_err", {15'd0, len_err}, {15'd0, m_le});
                check("held_residue", residue, m_res);
                check("held_frame_len", frame_len, m_len);
            end
            if (in_valid && in_ready) begin
                xfer_n     = cyc;
                busy_until = cyc + (in_last ? 9 : 8);
                if (in_last) done_at = cyc + 9;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b [16];
        int wait_cnt;

        // 0: minimal good frame
        b = '{default: 8'h00};
        b[0] = 8'h01; b[1] = 8'h10; b[2] = 8'h21;
        set_vec(0, b, 3, 1'b1, 1'b0, 16'h0000);
        // 1: "123456789" with its correct CRC
        b = '{default: 8'h00};
        for (int i = 0; i < 9; i++) b[i] = 8'h31 + 8'(i);
        b[9] = 8'h31; b[10] = 8'hC3;
        set_vec(1, b, 11, 1'b1, 1'b0, 16'h0000);
        // 2: same payload, low CRC byte off by one bit -> x^16 mod P
        b[10] = 8'hC2;
        set_vec(2, b, 11, 1'b0, 1'b0, 16'h1021);
        // 3: single byte -> length error
        b = '{default: 8'h00};
        b[0] = 8'h55;
        set_vec(3, b, 1, 1'b0, 1'b1, 16'h0A50);
        // 4: good frame right after the short one
        b = '{default: 8'h00};
        b[0] = 8'h01; b[1] = 8'h10; b[2] = 8'h21;
        set_vec(4, b, 3, 1'b1, 1'b0, 16'h0000);
        // 5: bad frame back-to-back after a good one
        b[2] = 8'h20;
        set_vec(5, b, 3, 1'b0, 1'b0, 16'h1021);
        // 6: shortest legal frame
        b = '{default: 8'h00};
        set_vec(6, b, 2, 1'b1, 1'b0, 16'h0000);
        // 7: high CRC byte corrupted by 0x01 -> x^24 mod P
        for (int i = 0; i < 9; i++) b[i] = 8'h31 + 8'(i);
        b[9] = 8'h30; b[10] = 8'hC3;
        set_vec(7, b, 11, 1'b0, 1'b0, 16'h3331);

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Gap-free pass (in_valid held high through SHIFT), then random gaps.
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < C_NVEC; v++) begin
                send_frame(v, pass == 1);
            end
        end

        // Reset during the 4th bit of the 2nd byte of a frame.
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h10, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, 1'b0);

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc16_frame_checker.md
# crc16_frame_checker

Receive-side counterpart of the team's byte-wise CRC-16 generator (polynomial x^16+x^12+x^5+1, zero initial value). It accepts a byte stream over a valid/ready handshake: a frame's payload bytes followed by the two CRC bytes the generator produced, high byte first. It divides the whole stream bit-serially, MSB first, and reports at end of frame whether the remainder is zero. It sits on the link ingress path, ahead of the frame buffer that decides whether to keep or drop each frame.

## Interface
- POLY, 16'h1021, generator polynomial without the x^16 term
- INIT, 16'h0000, remainder register value at reset and at the start of every frame
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data/in_last valid this cycle
- in_ready  output  1  checker can take a byte this cycle
- in_data  input  8  stream byte; payload, then CRC[15:8], then CRC[7:0]
- in_last  input  1  marks the final byte of the frame (CRC[7:0])
- frame_done  output  1  one-cycle pulse: frame result valid
- crc_ok  output  1  remainder was zero and the length was legal; held until the next frame_done
- len_err  output  1  frame had fewer than 2 bytes; held until the next frame_done
- residue  output  16  final remainder of the frame; held until the next frame_done
- frame_len  output  16  bytes accepted in the frame, CRC included, saturating at 16'hFFFF; held until the next frame_done

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE
  - in_ready=1.
  - Transfer occurs when in_valid && in_ready.
  - On transfer: latch in_data into the 8-bit shift register; latch in_last into last_q; set bit_cnt=0; increment the byte counter (saturating); go to SHIFT.
- SHIFT
  - in_ready=0.
  - Each cycle takes b = sreg[7]; fb = crc[15]^b; crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 0); sreg shifts left.
  - bit_cnt increments each cycle.
  - At bit_cnt==7: go to DONE if last_q, else IDLE.
- DONE
  - in_ready=0.
  - Assert frame_done for this one cycle.
  - Set residue=crc; len_err=(byte count<2); crc_ok=(crc==0)&&!len_err; frame_len=byte count.
  - Then reload crc=INIT, clear the byte counter, go to IDLE.
- A correct frame (payload M followed by the generator's CRC of M) leaves residue 16'h0000.
- With a corrupted CRC field C^e, residue = (e·x^16) mod P.
- in_valid while in_ready=0: no transfer. The source holds in_data/in_last stable until the transfer occurs.
- The byte counter saturates at 16'hFFFF. The CRC keeps processing every byte regardless.
- There is no frame-start input: the first byte accepted after DONE or reset begins a new frame.

## Timing
- Reset values:
  - state=IDLE, in_ready=1
  - crc=INIT, byte count=0, bit_cnt=0
  - frame_done=0, crc_ok=0, len_err=0, residue=16'h0000, frame_len=16'h0000
- Reset is asynchronous and takes effect mid-frame or mid-byte. The partial frame is discarded and no frame_done is issued.
- A byte transferred at cycle T is shifted in cycles T+1..T+8. in_ready is high again at T+9 (non-last byte).
- Throughput is 1 byte per 9 cycles.
- Last byte transferred at T: frame_done pulses at T+9, with the result outputs updated in the same cycle. in_ready returns at T+10.
- in_ready is a registered function of state only. It is never combinationally dependent on in_valid.

## Test plan
- Frame 0x01,0x10,0x21 (in_last on 0x21) -> frame_done 27 cycles after the first transfer; residue=16'h0000, crc_ok=1, len_err=0, frame_len=3.
- ASCII "123456789" then 0x31,0xC3 -> crc_ok=1, residue=0, frame_len=11. Same payload with trailer 0x31,0xC2 -> crc_ok=0, residue=16'h1021.
- Single byte 0x55 with in_last -> frame_done, len_err=1, crc_ok=0, frame_len=1. The following good frame 0x01,0x10,0x21 -> crc_ok=1, len_err=0.
- Random in_valid gaps and in_valid held high during SHIFT -> each byte consumed exactly once; results identical to the gap-free run; in_ready never high in SHIFT or DONE.
- Assert rst_n low during the 4th bit of the 2nd byte of a frame, release, then send 0x01,0x10,0x21 -> no frame_done for the aborted frame; all outputs at reset values; the new frame gives crc_ok=1.
- Back-to-back frames, a good one then a bad one (0x01,0x10,0x20) -> two frame_done pulses. First: crc_ok=1. Second: crc_ok=0, residue=16'h1021. crc_ok stays held between the pulses.
